vfr_flip_ctrl: RTL and testbench



---
 rtl/vfr_regs_pkg.sv | 45 ++++
 rtl/vfr_init_rom.sv | 44 ++++
 rtl/vfr_flip_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vfr_flip_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfr_regs_pkg.sv
// Register map, state encoding and INIT sequence length for the frame reader sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package vfr_regs_pkg;

    // Frame reader control slave word addresses
    localparam logic [4:0] REG_CTRL          = 5'd0;
    localparam logic [4:0] REG_STATUS        = 5'd1;
    localparam logic [4:0] REG_IRQ           = 5'd2;
    localparam logic [4:0] REG_FRAME_SEL     = 5'd3;
    localparam logic [4:0] REG_F0_BASE       = 5'd4;
    localparam logic [4:0] REG_F0_WORDS      = 5'd5;
    localparam logic [4:0] REG_F0_PATTERNS   = 5'd6;
    localparam logic [4:0] REG_F0_WIDTH      = 5'd8;
    localparam logic [4:0] REG_F0_HEIGHT     = 5'd9;
    localparam logic [4:0] REG_F0_INTERLACED = 5'd10;
    localparam logic [4:0] REG_F1_BASE       = 5'd11;
    localparam logic [4:0] REG_F1_WORDS      = 5'd12;
    localparam logic [4:0] REG_F1_PATTERNS   = 5'd13;
    localparam logic [4:0] REG_F1_WIDTH      = 5'd15;
    localparam logic [4:0] REG_F1_HEIGHT     = 5'd16;
    localparam logic [4:0] REG_F1_INTERLACED = 5'd17;

    // CTRL bit positions and the value that starts video with interrupts enabled
    localparam int CTRL_GO_BIT    = 0;
    localparam int CTRL_INTEN_BIT = 1;
    localparam logic [31:0] CTRL_RUN = (32'd1 << CTRL_GO_BIT) | (32'd1 << CTRL_INTEN_BIT);

    // Number of writes in the start-up programming sequence
    localparam int INIT_LEN = 14;

    typedef enum logic [3:0] {
        S_OFF,
        S_INIT,
        S_POLL_RD,
        S_POLL_CHK,
        S_IDLE,
        S_IRQ_CLR,
        S_FLIP,
        S_HOLD,
        S_STOP,
        S_ERR
    } state_t;

endpackage

// File: rtl/vfr_init_rom.sv
// Maps an INIT step index to the {address, data} pair written to the frame reader.
// Latency: combinational, 0 cycles.
// Backpressure: none; out-of-range indices return a harmless (CTRL, 0) pair.
module vfr_init_rom
    import vfr_regs_pkg::*;
#(
    parameter logic [31:0] FB0_BASE = 32'h0000_0000,
    parameter logic [31:0] FB1_BASE = 32'h0012_C000,
    parameter int          WIDTH    = 640,
    parameter int          HEIGHT   = 480
) (
    input  logic [3:0]  index,
    output logic [4:0]  address,
    output logic [31:0] data
);

    localparam logic [31:0] WORDS = 32'(WIDTH * HEIGHT);
    localparam logic [31:0] W32   = 32'(WIDTH);
    localparam logic [31:0] H32   = 32'(HEIGHT);

    // Both descriptors first, then select frame 0, then Go + IntEn last
    always_comb begin
        address = REG_CTRL;
        data    = 32'd0;
        case (index)
            4'd0:  begin address = REG_F0_BASE;       data = FB0_BASE; end
            4'd1:  begin address = REG_F0_WORDS;      data = WORDS;    end
            4'd2:  begin address = REG_F0_PATTERNS;   data = 32'd1;    end
            4'd3:  begin address = REG_F0_WIDTH;      data = W32;      end
            4'd4:  begin address = REG_F0_HEIGHT;     data = H32;      end
            4'd5:  begin address = REG_F0_INTERLACED; data = 32'd0;    end
            4'd6:  begin address = REG_F1_BASE;       data = FB1_BASE; end
            4'd7:  begin address = REG_F1_WORDS;      data = WORDS;    end
            4'd8:  begin address = REG_F1_PATTERNS;   data = 32'd1;    end
            4'd9:  begin address = REG_F1_WIDTH;      data = W32;      end
            4'd10: begin address = REG_F1_HEIGHT;     data = H32;      end
            4'd11: begin address = REG_F1_INTERLACED; data = 32'd0;    end
            4'd12: begin address = REG_FRAME_SEL;     data = 32'd0;    end
            4'd13: begin address = REG_CTRL;          data = CTRL_RUN; end
            default: begin address = REG_CTRL;        data = 32'd0;    end
        endcase
    end

endmodule

// File: rtl/vfr_flip_ctrl.sv
// Programs the frame reader, confirms it runs, then clears end-of-frame irqs and flips buffers on request.
// Latency: all outputs registered; irq seen in IDLE at t gives clear write at t+1, FRAME_SEL write at t+2.
// Backpressure: none on the slave (no waitrequest); swap_req is absorbed into a single pending flag.
module vfr_flip_ctrl
    import vfr_regs_pkg::*;
#(
    parameter logic [31:0] FB0_BASE = 32'h0000_0000,
    parameter logic [31:0] FB1_BASE = 32'h0012_C000,
    parameter int          WIDTH    = 640,
    parameter int          HEIGHT   = 480,
    parameter int          POLL_MAX = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        front_sel,
    output logic        running,
    output logic        error,
    input  logic        irq,
    output logic [4:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    input  logic [31:0] avm_readdata
);

    localparam int POLL_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX);

    state_t            state, state_nxt;
    logic [3:0]        idx, idx_nxt, rom_idx;
    logic [POLL_W-1:0] poll_cnt, poll_nxt;
    logic              hold_cnt, hold_nxt;
    logic              pending, pend_nxt;
    logic [4:0]        addr_nxt, rom_addr;
    logic [31:0]       wdata_nxt, rom_data;
    logic              wr_nxt, rd_nxt, ack_nxt, front_nxt, run_nxt, err_nxt;
    logic              unused_rd;

    // Only the running bit of STATUS is meaningful to the sequencer
    assign unused_rd = ^avm_readdata[31:1];

    // The bus shows the write for the step being entered, so look up one index ahead
    assign rom_idx = (state == S_INIT) ? idx + 4'd1 : 4'd0;

    vfr_init_rom #(
        .FB0_BASE (FB0_BASE),
        .FB1_BASE (FB1_BASE),
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT)
    ) u_rom (
        .index   (rom_idx),
        .address (rom_addr),
        .data    (rom_data)
    );

    // Next state plus the bus/status values that accompany the state being entered
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        poll_nxt  = poll_cnt;
        hold_nxt  = hold_cnt;
        pend_nxt  = pending;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        addr_nxt  = 5'd0;
        wdata_nxt = 32'd0;
        ack_nxt   = 1'b0;
        front_nxt = front_sel;
        run_nxt   = running;
        err_nxt   = error;

        if (swap_req && state != S_OFF && state != S_ERR)
            pend_nxt = 1'b1;

        case (state)
            S_OFF: begin
                if (enable) begin
                    state_nxt = S_INIT;
                    idx_nxt   = 4'd0;
                    front_nxt = 1'b0;
                    wr_nxt    = 1'b1;
                    addr_nxt  = rom_addr;
                    wdata_nxt = rom_data;
                end
            end
            S_INIT: begin
                if (idx == 4'(INIT_LEN - 1)) begin
                    state_nxt = S_POLL_RD;
                    poll_nxt  = '0;
                    rd_nxt    = 1'b1;
                    addr_nxt  = REG_STATUS;
                end else begin
                    idx_nxt   = idx + 4'd1;
                    wr_nxt    = 1'b1;
                    addr_nxt  = rom_addr;
                    wdata_nxt = rom_data;
                end
            end
            S_POLL_RD: state_nxt = S_POLL_CHK;
            S_POLL_CHK: begin
                if (avm_readdata[0]) begin
                    run_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (poll_cnt == POLL_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end else begin
                    poll_nxt  = poll_cnt + 1'b1;
                    state_nxt = S_POLL_RD;
                    rd_nxt    = 1'b1;
                    addr_nxt  = REG_STATUS;
                end
            end
            S_IDLE: begin
                if (!enable) begin
                    state_nxt = S_STOP;
                    wr_nxt    = 1'b1;
                    addr_nxt  = REG_CTRL;
                    run_nxt   = 1'b0;
                end else if (irq) begin
                    state_nxt = S_IRQ_CLR;
                    wr_nxt    = 1'b1;
                    addr_nxt  = REG_IRQ;
                    wdata_nxt = 32'd1;
                end
            end
            S_IRQ_CLR: begin
                // A request arriving in this very cycle still counts for this flip
                if (pend_nxt) begin
                    state_nxt = S_FLIP;
                    wr_nxt    = 1'b1;
                    addr_nxt  = REG_FRAME_SEL;
                    wdata_nxt = {31'd0, ~front_sel};
                    front_nxt = ~front_sel;
                    ack_nxt   = 1'b1;
                    pend_nxt  = 1'b0;
                end else begin
                    state_nxt = S_HOLD;
                    hold_nxt  = 1'b0;
                end
            end
            S_FLIP: begin
                state_nxt = S_HOLD;
                hold_nxt  = 1'b0;
            end
            S_HOLD: begin
                // irq may still be high while the slave deasserts it; ignore it here
                if (hold_cnt) state_nxt = S_IDLE;
                else          hold_nxt  = 1'b1;
            end
            S_STOP: begin
                run_nxt   = 1'b0;
                pend_nxt  = 1'b0;
                state_nxt = S_OFF;
            end
            S_ERR: state_nxt = S_ERR;
            default: state_nxt = S_OFF;
        endcase
    end

    // State and registered outputs; reset wins everywhere, including mid-INIT
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state         <= S_OFF;
            idx           <= 4'd0;
            poll_cnt      <= '0;
            hold_cnt      <= 1'b0;
            pending       <= 1'b0;
            avm_address   <= 5'd0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'd0;
            avm_read      <= 1'b0;
            swap_ack      <= 1'b0;
            front_sel     <= 1'b0;
            running       <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            poll_cnt      <= poll_nxt;
            hold_cnt      <= hold_nxt;
            pending       <= pend_nxt;
            avm_address   <= addr_nxt;
            avm_write     <= wr_nxt;
            avm_writedata <= wdata_nxt;
            avm_read      <= rd_nxt;
            swap_ack      <= ack_nxt;
            front_sel     <= front_nxt;
            running       <= run_nxt;
            error         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vfr_flip_ctrl.sv
// Bench for vfr_flip_ctrl: slave model, bus monitor and a frame-level flip model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vfr_flip_ctrl;

    localparam logic [31:0] FB0 = 32'h0000_0000;
    localparam logic [31:0] FB1 = 32'h0012_C000;
    localparam int          W   = 640;
    localparam int          H   = 480;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
    } acc_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset, enable, swap_req, irq;
    logic        swap_ack, front_sel, running, error;
    logic [4:0]  avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    logic [31:0] status = 32'd1;
    acc_t        log[$];
    logic        front_h[1024];
    logic        ack_h[1024];
    logic        run_h[1024];
    logic        err_h[1024];
    logic [4:0]  ea[14];
    logic [31:0] ed[14];
    int          offs[6] = '{0, 1, 2, 4, 5, 6};
    logic        mfront;
    bit          mpend;

    vfr_flip_ctrl dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .enable        (enable),
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .front_sel     (front_sel),
        .running       (running),
        .error         (error),
        .irq           (irq),
        .avm_address   (avm_address),
        .avm_write     (avm_write),
        .avm_writedata (avm_writedata),
        .avm_read      (avm_read),
        .avm_readdata  (avm_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    // Cycle counter (cycle 0 = first cycle with reset low) and STATUS slave, data one cycle after read
    always @(posedge clk_clk) begin
        if (reset_reset) cyc <= 0;
        else             cyc <= cyc + 1;
        avm_readdata <= avm_read ? status : 32'd0;
    end

    // Bus and status monitor, sampled mid-cycle
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (avm_write || avm_read)
                log.push_back('{cyc, avm_write, avm_address, avm_writedata});
            front_h[cyc % 1024] = front_sel;
            ack_h[cyc % 1024]   = swap_ack;
            run_h[cyc % 1024]   = running;
            err_h[cyc % 1024]   = error;
            if (swap_ack) ack_cnt++;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_addr"},  32'(avm_address), 32'd0);
        chk({pfx, "_wr"},    32'(avm_write), 32'd0);
        chk({pfx, "_wdata"}, avm_writedata, 32'd0);
        chk({pfx, "_rd"},    32'(avm_read), 32'd0);
        chk({pfx, "_ack"},   32'(swap_ack), 32'd0);
        chk({pfx, "_front"}, 32'(front_sel), 32'd0);
        chk({pfx, "_run"},   32'(running), 32'd0);
        chk({pfx, "_err"},   32'(error), 32'd0);
    endtask

    // Expected: 14 writes at c0+1.., then the first STATUS read at c0+15
    task automatic check_init(input int c0);
        chk("init_size", 32'(log.size() >= 15), 32'd1);
        if (log.size() >= 15) begin
            for (int k = 0; k < 14; k++) begin
                chk($sformatf("init%0d_cyc", k), 32'(log[k].cyc), 32'(c0 + 1 + k));
                chk($sformatf("init%0d_wa", k), 32'({log[k].wr, log[k].a}), 32'({1'b1, ea[k]}));
                chk($sformatf("init%0d_d", k), log[k].d, ed[k]);
            end
            chk("poll0_cyc", 32'(log[14].cyc), 32'(c0 + 15));
            chk("poll0_wa", 32'({log[14].wr, log[14].a}), 32'({1'b0, 5'd1}));
        end
    endtask

    // One frame: optional requests in IDLE, irq for len cycles, optional requests at t+1 / t+2
    task automatic do_frame(input int nreq, input int len, input bit r1, input bit r2);
        int   t;
        int   a0;
        bit   flip;
        logic fold;
        log.delete();
        a0   = ack_cnt;
        fold = mfront;
        for (int i = 0; i < nreq; i++) begin
            step(); swap_req = 1'b1;
            step(); swap_req = 1'b0;
            mpend = 1'b1;
        end
        step();
        t   = cyc;
        irq = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            irq      = (k < len);
            swap_req = (k == 1 && r1) || (k == 2 && r2);
        end
        swap_req = 1'b0;
        if (r1) mpend = 1'b1;
        flip = mpend;
        if (flip) begin
            mfront = ~mfront;
            mpend  = 1'b0;
        end
        if (r2) mpend = 1'b1;
        while (cyc < t + 8) step();
        chk("frame_nacc", 32'(log.size()), flip ? 32'd2 : 32'd1);
        if (log.size() >= 1) begin
            chk("clr_cyc", 32'(log[0].cyc), 32'(t + 1));
            chk("clr_wa", 32'({log[0].wr, log[0].a}), 32'({1'b1, 5'd2}));
            chk("clr_d", log[0].d, 32'd1);
        end
        if (flip && log.size() >= 2) begin
            chk("flip_cyc", 32'(log[1].cyc), 32'(t + 2));
            chk("flip_wa", 32'({log[1].wr, log[1].a}), 32'({1'b1, 5'd3}));
            chk("flip_d", log[1].d, 32'(mfront));
        end
        chk("front_t1", 32'(front_h[(t + 1) % 1024]), 32'(fold));
        chk("front_t2", 32'(front_h[(t + 2) % 1024]), 32'(mfront));
        chk("ack_t2", 32'(ack_h[(t + 2) % 1024]), 32'(flip));
        chk("ack_cnt", 32'(ack_cnt - a0), 32'(flip));
    endtask

    initial begin
        int t;
        int e;
        int nrd;
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 6; j++) begin
                ea[f * 6 + j] = 5'(4 + 7 * f + offs[j]);
                case (j)
                    0: ed[f * 6 + j] = (f == 0) ? FB0 : FB1;
                    1: ed[f * 6 + j] = 32'(W * H);
                    2: ed[f * 6 + j] = 32'd1;
                    3: ed[f * 6 + j] = 32'(W);
                    4: ed[f * 6 + j] = 32'(H);
                    default: ed[f * 6 + j] = 32'd0;
                endcase
            end
        end
        ea[12] = 5'd3; ed[12] = 32'd0;
        ea[13] = 5'd0; ed[13] = 32'd3;

        reset_reset = 1'b1; enable = 1'b0; swap_req = 1'b0; irq = 1'b0;
        status = 32'd1;
        repeat (3) step();
        chk_reset("rst0");

        // Startup with enable at reset release
        log.delete();
        reset_reset = 1'b0;
        enable      = 1'b1;
        while (cyc < 20) step();
        check_init(0);
        chk("words_data", ed[1], 32'd307200);
        chk("run_c16", 32'(run_h[16]), 32'd0);
        chk("run_c17", 32'(run_h[17]), 32'd1);
        chk("front_start", 32'(front_sel), 32'd0);

        // Directed frames, then randomized ones
        mfront = 1'b0;
        mpend  = 1'b0;
        do_frame(1, 1, 1'b0, 1'b0);
        do_frame(0, 1, 1'b0, 1'b0);
        do_frame(2, 1, 1'b0, 1'b0);
        do_frame(0, 2, 1'b1, 1'b0);
        do_frame(1, 1, 1'b0, 1'b1);
        do_frame(0, 3, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++)
            do_frame(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (!mfront) do_frame(1, 1, 1'b0, 1'b0);

        // Drop enable in IDLE, then re-enable
        step();
        t = cyc;
        enable = 1'b0;
        log.delete();
        while (cyc < t + 4) step();
        chk("stop_nacc", 32'(log.size()), 32'd1);
        if (log.size() >= 1) begin
            chk("stop_cyc", 32'(log[0].cyc), 32'(t + 1));
            chk("stop_wa", 32'({log[0].wr, log[0].a}), 32'({1'b1, 5'd0}));
            chk("stop_d", log[0].d, 32'd0);
        end
        chk("stop_run", 32'(run_h[(t + 2) % 1024]), 32'd0);
        e = cyc;
        log.delete();
        enable = 1'b1;
        while (cyc < e + 20) step();
        check_init(e);
        chk("reinit_front", 32'(front_h[(e + 1) % 1024]), 32'd0);
        chk("reinit_run", 32'(run_h[(e + 17) % 1024]), 32'd1);

        // Reset in the middle of INIT, then a status that never reports running
        reset_reset = 1'b1;
        repeat (2) step();
        log.delete();
        reset_reset = 1'b0;
        while (cyc < 8) step();
        chk("mid_nacc", 32'(log.size()), 32'd8);
        if (log.size() >= 8) chk("mid_idx7_addr", 32'(log[7].a), 32'd12);
        reset_reset = 1'b1;
        step();
        chk_reset("rst_mid");
        status = 32'hFFFF_FFFE;
        log.delete();
        reset_reset = 1'b0;
        while (cyc < 560) step();
        check_init(0);
        nrd = 0;
        foreach (log[i]) if (!log[i].wr) nrd++;
        chk("err_nreads", 32'(nrd), 32'd256);
        chk("err_last_cyc", 32'(log[log.size() - 1].cyc), 32'd525);
        chk("err_c526", 32'(err_h[526]), 32'd0);
        chk("err_c527", 32'(err_h[527]), 32'd1);
        chk("err_sticky", 32'(error), 32'd1);
        chk("err_run", 32'(running), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
